// File: rtl/spi_pkg.sv
// spi_pkg: command codes and FSM states shared by the SPI responder.
package spi_pkg;
    localparam logic [7:0] CMD_WR = 8'h02;
    localparam logic [7:0] CMD_RD = 8'h03;
    typedef enum logic [2:0] {IDLE, CMD, ADDR, WR_DATA, RD_DATA, DISCARD} state_t;
endpackage

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: pin synchronizers plus edge detection for sck and cs.
module spi_slave_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sck,
    input  logic cs,
    input  logic sdi,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_rise,
    output logic cs_fall,
    output logic cs_s,
    output logic sdi_s
);
    logic [SYNC_STAGES-1:0] sck_q, cs_q, sdi_q;
    logic sck_d, cs_d;
    // cs resets high so leaving reset never looks like a frame start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q <= '0;
            cs_q  <= '1;
            sdi_q <= '0;
            sck_d <= 1'b0;
            cs_d  <= 1'b1;
        end else begin
            sck_q <= {sck_q[SYNC_STAGES-2:0], sck};
            cs_q  <= {cs_q[SYNC_STAGES-2:0], cs};
            sdi_q <= {sdi_q[SYNC_STAGES-2:0], sdi};
            sck_d <= sck_q[SYNC_STAGES-1];
            cs_d  <= cs_q[SYNC_STAGES-1];
        end
    end
    assign sck_rise = sck_q[SYNC_STAGES-1] & ~sck_d;
    assign sck_fall = ~sck_q[SYNC_STAGES-1] & sck_d;
    assign cs_rise  = cs_q[SYNC_STAGES-1] & ~cs_d;
    assign cs_fall  = ~cs_q[SYNC_STAGES-1] & cs_d;
    assign cs_s     = cs_q[SYNC_STAGES-1];
    assign sdi_s    = sdi_q[SYNC_STAGES-1];
endmodule

// File: rtl/spi_slave.sv
// spi_slave: oversampled mode-0 LSB-first SPI responder bridging to a register port.
module spi_slave
    import spi_pkg::*;
#(
    parameter int ADDR_WIDTH  = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  spi_sck,
    input  logic                  spi_cs,
    input  logic                  spi_sdi,
    output logic                  spi_sdo,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [7:0]            wr_data,
    output logic                  rd_req,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [7:0]            rd_data,
    output logic                  busy,
    output logic                  cmd_err
);
    localparam int ADDR_BYTES = ADDR_WIDTH / 8;
    localparam int BCW = $clog2(ADDR_BYTES + 1);
    state_t state;
    logic sck_rise, sck_fall, cs_rise, cs_fall, cs_s, sdi_s;
    logic byte_done, last_addr, is_rd, rd_pend, tx_load;
    logic [2:0] bit_cnt;
    logic [BCW-1:0] byte_cnt;
    logic [7:0] rx_sh, rx_byte, tx_sh, tx_buf;
    logic [ADDR_WIDTH-1:0] addr, addr_asm;
    spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk), .rst_n(rst_n), .sck(spi_sck), .cs(spi_cs), .sdi(spi_sdi),
        .sck_rise(sck_rise), .sck_fall(sck_fall), .cs_rise(cs_rise), .cs_fall(cs_fall),
        .cs_s(cs_s), .sdi_s(sdi_s)
    );
    assign rx_byte   = {sdi_s, rx_sh[7:1]};
    assign byte_done = sck_rise && bit_cnt == 3'd7 && state != IDLE;
    assign last_addr = byte_cnt == BCW'(ADDR_BYTES - 1);
    assign busy      = ~cs_s;
    assign spi_sdo   = state == RD_DATA && tx_sh[0];
    always_comb begin
        addr_asm = addr;
        for (int i = 0; i < ADDR_BYTES; i++)
            if (byte_cnt == BCW'(i)) addr_asm[i*8 +: 8] = rx_byte;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            rx_sh    <= '0;
            tx_sh    <= '0;
            tx_buf   <= '0;
            tx_load  <= 1'b0;
            rd_pend  <= 1'b0;
            is_rd    <= 1'b0;
            addr     <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            rd_req   <= 1'b0;
            rd_addr  <= '0;
            cmd_err  <= 1'b0;
        end else begin
            wr_en   <= 1'b0;
            rd_req  <= 1'b0;
            cmd_err <= 1'b0;
            rd_pend <= rd_req;
            if (sck_rise && state != IDLE) begin
                rx_sh   <= rx_byte;
                bit_cnt <= bit_cnt + 3'd1;
            end
            // a prefetched byte replaces the shift register on the first fall after it lands
            if (sck_fall && state == RD_DATA) begin
                tx_sh   <= tx_load ? tx_buf : tx_sh >> 1;
                tx_load <= 1'b0;
            end
            if (rd_pend) begin
                tx_buf  <= rd_data;
                tx_load <= 1'b1;
            end
            if (byte_done) begin
                case (state)
                    CMD: begin
                        is_rd   <= rx_byte == CMD_RD;
                        state   <= (rx_byte == CMD_WR || rx_byte == CMD_RD) ? ADDR : DISCARD;
                        cmd_err <= !(rx_byte == CMD_WR || rx_byte == CMD_RD);
                    end
                    ADDR: begin
                        addr     <= addr_asm;
                        byte_cnt <= byte_cnt + BCW'(1);
                        if (last_addr) begin
                            state <= is_rd ? RD_DATA : WR_DATA;
                            if (is_rd) begin
                                rd_req  <= 1'b1;
                                rd_addr <= addr_asm;
                                addr    <= addr_asm + 1'b1;
                            end
                        end
                    end
                    WR_DATA: begin
                        wr_en   <= 1'b1;
                        wr_addr <= addr;
                        wr_data <= rx_byte;
                        addr    <= addr + 1'b1;
                    end
                    RD_DATA: begin
                        rd_req  <= 1'b1;
                        rd_addr <= addr;
                        addr    <= addr + 1'b1;
                    end
                    default: ;
                endcase
            end
            if (state == IDLE && cs_fall) begin
                state    <= CMD;
                bit_cnt  <= '0;
                byte_cnt <= '0;
                addr     <= '0;
                tx_sh    <= '0;
                tx_load  <= 1'b0;
            end
            if (cs_rise) state <= IDLE;
        end
    end
endmodule
